// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, 4x4 key map and idle levels shared by the keypad emulator and scanner
package keypad_pkg;
  localparam logic [3:0] KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF;
  localparam logic [3:0] ROW_IDLE = 4'b1111;
  localparam logic [3:0] COL_IDLE = 4'b1111;
  localparam int SCAN_DWELL = 65536;
  typedef enum logic [2:0] {S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP} state_t;
  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } rc_t;
  function automatic rc_t key_to_rc(input logic [3:0] code);
    case (code)
      KEY_1:   return {2'd0, 2'd0};
      KEY_2:   return {2'd0, 2'd1};
      KEY_3:   return {2'd0, 2'd2};
      KEY_A:   return {2'd0, 2'd3};
      KEY_4:   return {2'd1, 2'd0};
      KEY_5:   return {2'd1, 2'd1};
      KEY_6:   return {2'd1, 2'd2};
      KEY_B:   return {2'd1, 2'd3};
      KEY_7:   return {2'd2, 2'd0};
      KEY_8:   return {2'd2, 2'd1};
      KEY_9:   return {2'd2, 2'd2};
      KEY_C:   return {2'd2, 2'd3};
      KEY_E:   return {2'd3, 2'd0};
      KEY_0:   return {2'd3, 2'd1};
      KEY_F:   return {2'd3, 2'd2};
      default: return {2'd3, 2'd3};
    endcase
  endfunction
endpackage

// File: rtl/keypad_bounce_gen.sv
// keypad_bounce_gen: toggling contact waveform for the bounce phases of a press
module keypad_bounce_gen #(
  parameter int TOGGLES = 0,
  parameter int PERIOD  = 16,
  parameter int CNT_W   = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic start_closed_i,
  output logic closed_o,
  output logic last_o
);
  localparam int TW = TOGGLES > 1 ? $clog2(TOGGLES) : 1;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [TW-1:0] tog_q, tog_d;
  logic wrap;
  always_comb begin
    wrap = tmr_q == CNT_W'(1);
    tmr_d = wrap ? CNT_W'(PERIOD) : tmr_q - 1'b1;
    tog_d = wrap ? tog_q + 1'b1 : tog_q;
  end
  // Counters rest at their start values whenever the bounce phase is not running
  always_ff @(posedge clk) begin
    tmr_q <= (!reset || !run_i) ? CNT_W'(PERIOD) : tmr_d;
    tog_q <= (!reset || !run_i) ? '0 : tog_d;
  end
  assign closed_o = start_closed_i ^ tog_q[0];
  assign last_o = run_i && wrap && int'(tog_q) == TOGGLES - 1;
endmodule

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: contact side of a 4x4 matrix keypad, pressing one
// handshaken key code for a timed hold with optional bounce at both edges
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 300000,
  parameter int GAP_CYCLES     = 300000,
  parameter int BOUNCE_TOGGLES = 0,
  parameter int BOUNCE_PERIOD  = 16,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       busy,
  output logic       done
);
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_timing
    $error("keypad_matrix_emulator: HOLD_CYCLES and GAP_CYCLES must be at least 1");
  end
  if (BOUNCE_PERIOD < 1 || BOUNCE_TOGGLES % 2 != 0) begin : g_bad_bounce
    $error("keypad_matrix_emulator: BOUNCE_PERIOD must be >= 1 and BOUNCE_TOGGLES even");
  end
  if (HOLD_CYCLES <= 4 * SCAN_DWELL) begin : g_short_hold
    $info("keypad_matrix_emulator: HOLD_CYCLES shorter than one scanner sweep");
  end
  localparam bit BOUNCE = BOUNCE_TOGGLES > 0;
  state_t state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  rc_t rc_q;
  logic done_q, done_d;
  logic b_closed, b_last, closed;
  keypad_bounce_gen #(
    .TOGGLES(BOUNCE_TOGGLES),
    .PERIOD (BOUNCE_PERIOD),
    .CNT_W  (CNT_W)
  ) u_bounce (
    .clk           (clk),
    .reset         (reset),
    .run_i         (state_q == S_BOUNCE_IN || state_q == S_BOUNCE_OUT),
    .start_closed_i(state_q == S_BOUNCE_IN),
    .closed_o      (b_closed),
    .last_o        (b_last)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tmr_q <= '0;
      rc_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      rc_q <= (key_ready && key_valid) ? key_to_rc(key_code) : rc_q;
      done_q <= done_d;
    end
  end
  // Timer reloads on every state entry; HOLD and GAP count it down to 1
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (key_valid) begin
        state_d = BOUNCE ? S_BOUNCE_IN : S_HOLD;
        tmr_d = CNT_W'(HOLD_CYCLES);
      end
      S_BOUNCE_IN: if (b_last) begin
        state_d = S_HOLD;
        tmr_d = CNT_W'(HOLD_CYCLES);
      end
      S_HOLD: begin
        state_d = tmr_q == CNT_W'(1) ? (BOUNCE ? S_BOUNCE_OUT : S_GAP) : S_HOLD;
        tmr_d = tmr_q == CNT_W'(1) ? CNT_W'(GAP_CYCLES) : tmr_q - 1'b1;
      end
      S_BOUNCE_OUT: if (b_last) begin
        state_d = S_GAP;
        tmr_d = CNT_W'(GAP_CYCLES);
      end
      S_GAP: begin
        state_d = tmr_q == CNT_W'(1) ? S_IDLE : S_GAP;
        tmr_d = tmr_q - 1'b1;
        done_d = tmr_q == CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    key_ready = state_q == S_IDLE;
    busy = !key_ready;
    done = done_q;
    closed = state_q == S_HOLD ||
             ((state_q == S_BOUNCE_IN || state_q == S_BOUNCE_OUT) && b_closed);
    cols = (closed && !rows[rc_q.row]) ? ~(4'b0001 << rc_q.col) : COL_IDLE;
  end
endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable 4x4 matrix-keypad model: the contact side of the row/column interface that the scanner drives.
- Accepts a key code over a valid/ready handshake, then closes the matching row/column contact for a programmed time, with optional contact bounce.
- Used in FPGA self-test and bench builds in place of the physical keypad; feeds the scanner, which feeds the FIFO.

Parameters:
- HOLD_CYCLES, 300000, cycles contact stays closed; must exceed one full scan of 4 x 65536 cycles.
- GAP_CYCLES, 300000, cycles contact stays open after release before the next key is accepted.
- BOUNCE_TOGGLES, 0, contact-state toggles at press and at release; even value, 0 = clean edges.
- BOUNCE_PERIOD, 16, cycles between bounce toggles; must be ≥1.
- CNT_W, 20, timer width; must hold max(HOLD_CYCLES, GAP_CYCLES, BOUNCE_PERIOD).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-low reset
- key_code  input  4  key to press (hex legend value)
- key_valid  input  1  request to press key_code
- key_ready  output  1  emulator idle, request accepted this cycle if key_valid
- rows  input  4  row drive from scanner, active-low
- cols  output  4  column sense to scanner, active-low, idle 4'b1111
- busy  output  1  press sequence in progress
- done  output  1  one-cycle pulse when GAP ends

Behaviour:
- Reset (reset==0 at posedge): state IDLE, contact open, timer 0, latched code 0. Outputs: key_ready=1, busy=0, done=0, cols=4'b1111.
- Reset mid-sequence aborts it; cols is 4'b1111 from the first cycle after the reset edge.
- Key map (row, col): code 1,2,3,A = row0 col0..3; 4,5,6,B = row1 col0..3; 7,8,9,C = row2 col0..3; E,0,F,D = row3 col0..3.
- Row r is active when rows[r]==0; col c is asserted by cols[c]=0.
- cols is combinational from rows and registered state: if contact closed and rows[r_lat]==0, then cols = ~(4'b0001 << c_lat); else 4'b1111.
- Several rows low at once still asserts the column whenever rows[r_lat] is low. There is no ghosting of other keys.
- key_ready = (state==IDLE). busy = !key_ready.
- Handshake: when key_valid && key_ready, latch (r_lat, c_lat) from key_code and leave IDLE next cycle. key_code is don't-care at other times.
- FSM:
  - IDLE: accept request and load timer. Go to BOUNCE_IN if BOUNCE_TOGGLES>0, else HOLD.
  - BOUNCE_IN: contact toggles every BOUNCE_PERIOD cycles, starting closed. After BOUNCE_TOGGLES toggles, go to HOLD; contact ends closed.
  - HOLD: contact closed exactly HOLD_CYCLES cycles. Then go to BOUNCE_OUT if BOUNCE_TOGGLES>0, else GAP.
  - BOUNCE_OUT: contact toggles every BOUNCE_PERIOD cycles, starting open. After BOUNCE_TOGGLES toggles, go to GAP; contact ends open.
  - GAP: contact open GAP_CYCLES cycles. Then go to IDLE, with done=1 for the cycle IDLE is entered.
- Latency: contact closes on the cycle after acceptance. Without bounce, accept→done = 1 + HOLD_CYCLES + GAP_CYCLES cycles.
- A new request is accepted in the same cycle done pulses (IDLE, ready=1).
- Timer is a down-counter, reloaded on each state entry. A value of 1 means one cycle in that state. HOLD_CYCLES=0 or GAP_CYCLES=0 is illegal; flag it with an elaboration check.

Decomposition:
- Shared package keypad_pkg:
  - key-code constants KEY_0..KEY_F
  - key_to_rc function (code → 2-bit row, 2-bit col), defining the map above
  - ROW_IDLE / COL_IDLE = 4'b1111
  - the scanner's row-dwell constant 65536, used for the HOLD_CYCLES check
- One sub-module: keypad_bounce_gen, a timer plus toggle counter generating the contact waveform for the BOUNCE_* states.
- The FSM and the cols logic stay in the top module.

Test Plan:
- Reset held low 3 cycles, mid-HOLD with HOLD=8 -> cols=1111, key_ready=1, busy=0 the cycle after the reset edge.
- HOLD=8, GAP=4, no bounce; send code 5 with rows=1101 -> cols=1101 for exactly 8 cycles, 1111 for 4, done one cycle; accept→done = 13 cycles.
- Same setup, code D, rows cycling 1110/1101/1011/0111 each cycle -> cols=0111 only while rows==0111 during HOLD; otherwise 1111.
- BOUNCE_TOGGLES=4, BOUNCE_PERIOD=2, code 1, rows=1110 -> contact pattern closed/open/closed/open over 8 cycles, then 8 cycles steady closed, then the mirror pattern on release.
- key_valid held high with codes A then 0 back-to-back -> second accepted on the done cycle; no cycle with key_ready=1 and a dropped request.
- Integration with scanner and default params: press 3, 0, F, E -> scanner key_pressed once per press, key_value 3,0,F,E in order.
